voice_allocator: RTL and testbench

//  Schedules note events onto NUM_VOICES envelope/voice channels, allocating, retriggering or stealing voices.

---
 rtl/voice_allocator.sv | 221 ++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Schedules note-on/note-off events onto NUM_VOICES voice channels. It keeps a
// per-voice gate/busy/note table and emits one routing strobe per event toward
// the 1-bit demux feeding the ADSR blocks: route_sel picks the demux output,
// route_bit is the demux input (1 = gate-on/trigger, 0 = gate-off), and
// route_valid qualifies both.
//
// Event flow: IDLE -(accept)-> ALLOC -> ISSUE -> IDLE. The event is latched on
// accept, the target voice is chosen in ALLOC, and the routing strobe is
// presented during ISSUE. The table write happens on the edge that ends ISSUE,
// which is why a voice_done seen during ISSUE loses against an allocation of
// the same voice.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   ev_valid     in   note event present
//   ev_ready     out  event can be accepted (IDLE only)
//   ev_on        in   1 = note-on, 0 = note-off
//   ev_note      in   note number
//   voice_done   in   per-voice release-finished pulse
//   route_valid  out  one-cycle strobe qualifying route_sel/route_bit
//   route_sel    out  target voice index (demux select)
//   route_bit    out  1 = gate-on, 0 = gate-off (demux data)
//   gate         out  per-voice held gate
//   busy         out  per-voice allocated (gated or releasing)
//   voice_note   out  flattened note table, voice i at [i*NOTE_W +: NOTE_W]
//   stolen       out  strobe with route_valid when a busy voice was stolen
//   dropped      out  pulse when a note-off matched no gated voice
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int SEL_W      = 3,
    parameter int NOTE_W     = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NUM_VOICES-1:0]        voice_done,
    output logic                         route_valid,
    output logic [SEL_W-1:0]             route_sel,
    output logic                         route_bit,
    output logic [NUM_VOICES-1:0]        gate,
    output logic [NUM_VOICES-1:0]        busy,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic                         stolen,
    output logic                         dropped
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t state;

    // Event latched at accept (used in ALLOC and ISSUE)
    logic              ev_on_p1;
    logic [NOTE_W-1:0] ev_note_p1;

    // Target chosen in ALLOC, consumed in ISSUE
    logic [SEL_W-1:0]  tgt_p2;
    logic              vld_p2;

    logic [SEL_W-1:0]  steal_ptr;
    logic [NOTE_W-1:0] note_tab [NUM_VOICES];

    // Round-robin steal pointer advance, wrapping at NUM_VOICES even when
    // NUM_VOICES is not a power of two.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
        if (int'(p) == NUM_VOICES - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Priority search over the table. Scanning from the top down lets the
    // lowest matching index overwrite any higher one.
    logic             match_found;
    logic [SEL_W-1:0] match_idx;
    logic             free_found;
    logic [SEL_W-1:0] free_idx;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate[i] && (note_tab[i] == ev_note_p1)) begin
                match_found = 1'b1;
                match_idx   = SEL_W'(i);
            end
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = SEL_W'(i);
            end
        end
    end

    // Allocation decision: retrigger beats free voice beats steal. A note-off
    // only ever hits on a gated match; otherwise it is dropped.
    logic             alloc_hit;
    logic             alloc_steal;
    logic [SEL_W-1:0] alloc_idx;

    always_comb begin
        alloc_hit   = ev_on_p1;
        alloc_steal = ev_on_p1;
        alloc_idx   = steal_ptr;
        if (match_found) begin
            alloc_hit   = 1'b1;
            alloc_steal = 1'b0;
            alloc_idx   = match_idx;
        end else if (ev_on_p1 && free_found) begin
            alloc_steal = 1'b0;
            alloc_idx   = free_idx;
        end
    end

    // Stage p1: event capture on accept
    always_ff @(posedge clk) begin
        if (state == S_IDLE && ev_valid && ev_ready) begin
            ev_on_p1   <= ev_on;
            ev_note_p1 <= ev_note;
        end
    end

    // Stage p2: target register for the table write in ISSUE
    always_ff @(posedge clk) begin
        if (state == S_ALLOC) begin
            tgt_p2 <= alloc_idx;
        end
    end

    // Control FSM, routing outputs and voice table
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ev_ready    <= 1'b1;
            route_valid <= 1'b0;
            route_sel   <= '0;
            route_bit   <= 1'b0;
            gate        <= '0;
            busy        <= '0;
            stolen      <= 1'b0;
            dropped     <= 1'b0;
            steal_ptr   <= '0;
            vld_p2      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_tab[i] <= '0;
            end
        end else begin
            // Release completion; only a voice whose gate is already off may
            // be freed. An allocation later in this block overrides it.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_done[i] && !gate[i]) begin
                    busy[i] <= 1'b0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (ev_valid && ev_ready) begin
                        state    <= S_ALLOC;
                        ev_ready <= 1'b0;
                    end
                end

                S_ALLOC: begin
                    state       <= S_ISSUE;
                    vld_p2      <= alloc_hit;
                    route_valid <= alloc_hit;
                    stolen      <= alloc_steal;
                    dropped     <= !alloc_hit;
                    if (alloc_hit) begin
                        route_sel <= alloc_idx;
                        route_bit <= ev_on_p1;
                    end
                    if (alloc_steal) begin
                        steal_ptr <= next_ptr(steal_ptr);
                    end
                end

                S_ISSUE: begin
                    state       <= S_IDLE;
                    ev_ready    <= 1'b1;
                    route_valid <= 1'b0;
                    stolen      <= 1'b0;
                    dropped     <= 1'b0;
                    vld_p2      <= 1'b0;
                    if (vld_p2) begin
                        if (ev_on_p1) begin
                            gate[tgt_p2]     <= 1'b1;
                            busy[tgt_p2]     <= 1'b1;
                            note_tab[tgt_p2] <= ev_note_p1;
                        end else begin
                            gate[tgt_p2] <= 1'b0;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    ev_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_flat
        assign voice_note[g*NOTE_W +: NOTE_W] = note_tab[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// ---------------------------------------------------------------------------
// tb_voice_allocator
//
// Directed scenarios followed by a randomized event stream. Expected values
// come from a voice-table model kept in plain arrays and integers.
// ---------------------------------------------------------------------------
module tb_voice_allocator;

    localparam int NV = 8;
    localparam int SW = 3;
    localparam int NW = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           ev_valid;
    logic           ev_ready;
    logic           ev_on;
    logic [NW-1:0]  ev_note;
    logic [NV-1:0]  voice_done;
    logic           route_valid;
    logic [SW-1:0]  route_sel;
    logic           route_bit;
    logic [NV-1:0]  gate;
    logic [NV-1:0]  busy;
    logic [NV*NW-1:0] voice_note;
    logic           stolen;
    logic           dropped;

    int checks   = 0;
    int failures = 0;

    // Reference model of the voice table
    bit m_gate [NV];
    bit m_busy [NV];
    int m_note [NV];
    int m_ptr;
    int m_sel;
    bit m_bit;

    // Observations from the most recent ISSUE cycle
    int obs_sel;
    bit obs_stolen;
    bit obs_bit;

    voice_allocator #(.NUM_VOICES(NV), .SEL_W(SW), .NOTE_W(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_note    (ev_note),
        .voice_done (voice_done),
        .route_valid(route_valid),
        .route_sel  (route_sel),
        .route_bit  (route_bit),
        .gate       (gate),
        .busy       (busy),
        .voice_note (voice_note),
        .stolen     (stolen),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NV-1:0] exp_gate();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_gate[i];
        return v;
    endfunction

    function automatic logic [NV-1:0] exp_busy();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [NV*NW-1:0] exp_notes();
        logic [NV*NW-1:0] v;
        for (int i = 0; i < NV; i++) v[i*NW +: NW] = NW'(m_note[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 1'b0;
            m_busy[i] = 1'b0;
            m_note[i] = 0;
        end
        m_ptr = 0;
        m_sel = 0;
        m_bit = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},   64'(ev_ready),    64'(1));
        check({tag, "_rv"},      64'(route_valid), 64'(0));
        check({tag, "_sel"},     64'(route_sel),   64'(0));
        check({tag, "_bit"},     64'(route_bit),   64'(0));
        check({tag, "_gate"},    64'(gate),        64'(0));
        check({tag, "_busy"},    64'(busy),        64'(0));
        check({tag, "_notes"},   64'(voice_note),  64'(0));
        check({tag, "_stolen"},  64'(stolen),      64'(0));
        check({tag, "_dropped"}, 64'(dropped),     64'(0));
    endtask

    // Starts and ends just after a falling edge with the DUT idle. dv is
    // driven on voice_done during the ISSUE cycle.
    task automatic do_event(input bit on, input int note, input logic [NV-1:0] dv);
        int tgt;
        bit stl;
        bit drp;
        tgt = -1;
        stl = 1'b0;
        drp = 1'b0;
        for (int i = 0; i < NV; i++)
            if (tgt < 0 && m_gate[i] && m_note[i] == note) tgt = i;
        if (on) begin
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && !m_busy[i]) tgt = i;
            if (tgt < 0) begin
                tgt = m_ptr;
                stl = 1'b1;
            end
        end else if (tgt < 0) begin
            drp = 1'b1;
        end

        check("idle_ready", 64'(ev_ready), 64'(1));
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = NW'(note);
        @(negedge clk);
        ev_valid = 1'b0;
        check("alloc_rv",    64'(route_valid), 64'(0));
        check("alloc_ready", 64'(ev_ready),    64'(0));
        @(negedge clk);
        voice_done = dv;
        if (!drp) begin
            m_sel = tgt;
            m_bit = on;
        end
        check("issue_rv",      64'(route_valid), 64'(!drp));
        check("issue_sel",     64'(route_sel),   64'(m_sel));
        check("issue_bit",     64'(route_bit),   64'(m_bit));
        check("issue_stolen",  64'(stolen),      64'(stl));
        check("issue_dropped", 64'(dropped),     64'(drp));
        obs_sel    = int'(route_sel);
        obs_stolen = stolen;
        obs_bit    = route_bit;
        @(negedge clk);
        voice_done = '0;
        for (int i = 0; i < NV; i++)
            if (dv[i] && !m_gate[i]) m_busy[i] = 1'b0;
        if (!drp) begin
            if (on) begin
                m_gate[tgt] = 1'b1;
                m_busy[tgt] = 1'b1;
                m_note[tgt] = note;
            end else begin
                m_gate[tgt] = 1'b0;
            end
        end
        if (stl) m_ptr = (m_ptr + 1) % NV;
        check("post_gate",    64'(gate),        64'(exp_gate()));
        check("post_busy",    64'(busy),        64'(exp_busy()));
        check("post_notes",   64'(voice_note),  64'(exp_notes()));
        check("post_ready",   64'(ev_ready),    64'(1));
        check("post_rv",      64'(route_valid), 64'(0));
        check("post_stolen",  64'(stolen),      64'(0));
        check("post_dropped", 64'(dropped),     64'(0));
    endtask

    // voice_done pulse while idle
    task automatic pulse_done(input logic [NV-1:0] dv);
        voice_done = dv;
        @(negedge clk);
        voice_done = '0;
        for (int i = 0; i < NV; i++)
            if (dv[i] && !m_gate[i]) m_busy[i] = 1'b0;
        check("done_busy", 64'(busy), 64'(exp_busy()));
        check("done_gate", 64'(gate), 64'(exp_gate()));
    endtask

    initial begin
        rst        = 1'b1;
        ev_valid   = 1'b0;
        ev_on      = 1'b0;
        ev_note    = '0;
        voice_done = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset("rst_init");
        rst = 1'b0;

        // Fill all voices with notes 60..67
        for (int n = 60; n < 68; n++) begin
            do_event(1'b1, n, '0);
            check("fill_sel", 64'(obs_sel), 64'(n - 60));
        end
        check("fill_busy", 64'(busy), 64'(8'hFF));
        check("fill_gate", 64'(gate), 64'(8'hFF));

        // Steal round-robin from voice 0
        do_event(1'b1, 70, '0);
        check("steal0_sel",    64'(obs_sel),    64'(0));
        check("steal0_stolen", 64'(obs_stolen), 64'(1));
        check("steal0_note",   64'(voice_note[0 +: NW]), 64'(70));
        do_event(1'b1, 71, '0);
        check("steal1_sel", 64'(obs_sel), 64'(1));

        // Retrigger voice 3
        do_event(1'b1, 63, '0);
        check("retrig_sel", 64'(obs_sel), 64'(3));
        check("retrig_bit", 64'(obs_bit), 64'(1));

        // Release voice 2, finish release, reuse it
        do_event(1'b0, 62, '0);
        check("rel_sel",   64'(obs_sel), 64'(2));
        check("rel_bit",   64'(obs_bit), 64'(0));
        check("rel_gate2", 64'(gate[2]), 64'(0));
        check("rel_busy2", 64'(busy[2]), 64'(1));
        pulse_done(8'h04);
        check("rel_free2", 64'(busy[2]), 64'(0));
        do_event(1'b1, 90, '0);
        check("reuse_sel", 64'(obs_sel), 64'(2));

        // Unmatched note-off, done on a gated voice
        do_event(1'b0, 99, '0);
        pulse_done(8'h20);
        check("done_gated5", 64'(busy[5]), 64'(1));

        // voice_done on another voice during ISSUE, and on the stolen voice
        do_event(1'b0, 64, '0);
        do_event(1'b1, 72, 8'h14);
        check("simul_sel",   64'(obs_sel), 64'(2));
        check("simul_busy4", 64'(busy[4]), 64'(0));
        do_event(1'b1, 74, '0);
        do_event(1'b0, 63, '0);
        do_event(1'b1, 75, 8'h08);
        check("win_sel",    64'(obs_sel),    64'(3));
        check("win_stolen", 64'(obs_stolen), 64'(1));
        check("win_busy3",  64'(busy[3]),    64'(1));

        // Randomized event stream
        for (int k = 0; k < 60; k++) begin
            bit            on;
            int            note;
            logic [NV-1:0] dv;
            on   = ($urandom_range(0, 9) < 6);
            note = int'($urandom_range(60, 75));
            dv   = ($urandom_range(0, 3) == 0) ? NV'($urandom) : '0;
            do_event(on, note, dv);
            if ($urandom_range(0, 3) == 0) pulse_done(NV'($urandom));
        end

        // ev_valid held high: one accept every 3 cycles (unmatched note-offs)
        ev_valid = 1'b1;
        ev_on    = 1'b0;
        ev_note  = NW'(99);
        for (int k = 0; k < 9; k++) begin
            check("cont_ready",   64'(ev_ready),    64'(k % 3 == 0));
            check("cont_dropped", 64'(dropped),     64'(k % 3 == 2));
            check("cont_rv",      64'(route_valid), 64'(0));
            @(negedge clk);
        end
        ev_valid = 1'b0;
        check("cont_gate", 64'(gate), 64'(exp_gate()));
        check("cont_busy", 64'(busy), 64'(exp_busy()));

        // Reset asserted mid-event aborts it
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = NW'(80);
        @(negedge clk);
        ev_valid = 1'b0;
        rst      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("midrst_rv", 64'(route_valid), 64'(0));
        end
        rst = 1'b0;
        model_reset();
        check_reset("rst_mid");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("after_rst_rv", 64'(route_valid), 64'(0));
        end
        check("after_rst_busy", 64'(busy), 64'(0));

        // Steal pointer restarts at 0 after reset
        for (int n = 40; n < 49; n++) do_event(1'b1, n, '0);
        check("ptr_reset_sel", 64'(obs_sel), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
